// File: rtl/hit_resolver.sv
// Hit resolution for a two-player fighter. It decides when an active attack lands
// and owns health, hitstun, the round countdown and the KO/winner result. One clk is one frame.
module hit_resolver #(
    parameter int HEALTH_INIT    = 3,
    parameter int SPRITE_W       = 64,
    parameter int BASIC_REACH    = 32,
    parameter int DIR_REACH      = 48,
    parameter int BASIC_STUN     = 16,
    parameter int DIR_STUN       = 12,
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECS     = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state_p1,
    input  logic       attacking_p1,
    input  logic       dir_attacking_p1,
    input  logic [9:0] x_pos_p1,
    input  logic [2:0] state_p2,
    input  logic       attacking_p2,
    input  logic       dir_attacking_p2,
    input  logic [9:0] x_pos_p2,
    output logic [1:0] health_p1,
    output logic [1:0] health_p2,
    output logic       hitstun_p1,
    output logic       hitstun_p2,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic [6:0] round_timer,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [0:0] ST_FIGHT      = 1'b0;
    localparam logic [0:0] ST_KO         = 1'b1;
    localparam logic [2:0] ATTACK_ACTIVE = 3'd6;
    localparam int         FW            = $clog2(FRAMES_PER_SEC);

    logic [0:0]    state_q, state_d;
    logic [1:0]    health_p1_q, health_p1_d, health_p2_q, health_p2_d;
    logic [4:0]    stun_p1_q, stun_p1_d, stun_p2_q, stun_p2_d;
    logic          hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d;
    logic          lock_p1_q, lock_p1_d, lock_p2_q, lock_p2_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [6:0]    timer_q, timer_d;
    logic [1:0]    winner_q, winner_d;

    logic signed [10:0] gap_raw;
    logic [10:0]        gap, reach_p1, reach_p2;
    logic               fight, connect_p1, connect_p2;

    // One gap serves both players: P1 is always on the left facing right.
    assign gap_raw  = 11'({1'b0, x_pos_p2}) - 11'({1'b0, x_pos_p1}) - 11'(SPRITE_W);
    assign gap      = gap_raw[10] ? 11'd0 : gap_raw;
    assign reach_p1 = dir_attacking_p1 ? 11'(DIR_REACH) : 11'(BASIC_REACH);
    assign reach_p2 = dir_attacking_p2 ? 11'(DIR_REACH) : 11'(BASIC_REACH);

    assign fight      = (state_q == ST_FIGHT);
    assign hitstun_p1 = (stun_p1_q != 5'd0);
    assign hitstun_p2 = (stun_p2_q != 5'd0);

    // Both checks use pre-edge stun, so a same-frame trade lands on both sides.
    assign connect_p1 = fight && (state_p1 == ATTACK_ACTIVE) && !hitstun_p1 && !hitstun_p2
                        && !lock_p1_q && (gap < reach_p1);
    assign connect_p2 = fight && (state_p2 == ATTACK_ACTIVE) && !hitstun_p1 && !hitstun_p2
                        && !lock_p2_q && (gap < reach_p2);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        health_p1_d = health_p1_q;
        health_p2_d = health_p2_q;
        frame_d     = frame_q;
        timer_d     = timer_q;
        winner_d    = winner_q;
        hit_p1_d    = connect_p2;
        hit_p2_d    = connect_p1;
        lock_p1_d   = connect_p1 ? 1'b1 : ((state_p1 != ATTACK_ACTIVE) ? 1'b0 : lock_p1_q);
        lock_p2_d   = connect_p2 ? 1'b1 : ((state_p2 != ATTACK_ACTIVE) ? 1'b0 : lock_p2_q);
        stun_p1_d   = hitstun_p1 ? stun_p1_q - 5'd1 : 5'd0;
        stun_p2_d   = hitstun_p2 ? stun_p2_q - 5'd1 : 5'd0;

        if (connect_p2) begin
            stun_p1_d = dir_attacking_p2 ? 5'(DIR_STUN) : 5'(BASIC_STUN);
            if (health_p1_q != 2'd0) health_p1_d = health_p1_q - 2'd1;
        end
        if (connect_p1) begin
            stun_p2_d = dir_attacking_p1 ? 5'(DIR_STUN) : 5'(BASIC_STUN);
            if (health_p2_q != 2'd0) health_p2_d = health_p2_q - 2'd1;
        end

        if (fight) begin
            if (frame_q == FW'(FRAMES_PER_SEC - 1)) begin
                frame_d = '0;
                if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
            end else begin
                frame_d = frame_q + 1'b1;
            end

            if (health_p1_d == 2'd0 || health_p2_d == 2'd0 || timer_d == 7'd0) begin
                state_d   = ST_KO;
                stun_p1_d = 5'd0;
                stun_p2_d = 5'd0;
                // A health KO outranks a timeout landing on the same frame.
                if (health_p1_d == 2'd0 && health_p2_d == 2'd0) winner_d = 2'b11;
                else if (health_p2_d == 2'd0)                   winner_d = 2'b01;
                else if (health_p1_d == 2'd0)                   winner_d = 2'b10;
                else if (health_p1_d > health_p2_d)             winner_d = 2'b01;
                else if (health_p1_d < health_p2_d)             winner_d = 2'b10;
                else                                            winner_d = 2'b11;
            end
        end else begin
            stun_p1_d = 5'd0;
            stun_p2_d = 5'd0;
            hit_p1_d  = 1'b0;
            hit_p2_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state is built above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FIGHT;
            health_p1_q <= 2'(HEALTH_INIT);
            health_p2_q <= 2'(HEALTH_INIT);
            stun_p1_q   <= 5'd0;
            stun_p2_q   <= 5'd0;
            hit_p1_q    <= 1'b0;
            hit_p2_q    <= 1'b0;
            lock_p1_q   <= 1'b0;
            lock_p2_q   <= 1'b0;
            frame_q     <= '0;
            timer_q     <= 7'(ROUND_SECS);
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            health_p1_q <= health_p1_d;
            health_p2_q <= health_p2_d;
            stun_p1_q   <= stun_p1_d;
            stun_p2_q   <= stun_p2_d;
            hit_p1_q    <= hit_p1_d;
            hit_p2_q    <= hit_p2_d;
            lock_p1_q   <= lock_p1_d;
            lock_p2_q   <= lock_p2_d;
            frame_q     <= frame_d;
            timer_q     <= timer_d;
            winner_q    <= winner_d;
        end
    end

    assign health_p1   = health_p1_q;
    assign health_p2   = health_p2_q;
    assign hit_p1      = hit_p1_q;
    assign hit_p2      = hit_p2_q;
    assign round_timer = timer_q;
    assign game_over   = (state_q == ST_KO);
    assign winner      = winner_q;

endmodule
